// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
//   Shares one SPI configuration flash between two SPI masters (requester 0:
//   bootloader, requester 1: user/warmboot reader). Grants are round-robin.
//   Ownership only changes while the owner's chip select is high. A CS-high
//   guard gap is always inserted before a new owner drives the flash.
//
// Ports
//   clk_48mhz   in   system clock
//   reset       in   synchronous active-high reset
//   rq_req      in   [1:0] per-requester bus request (level)
//   rq_gnt      out  [1:0] per-requester grant, one-hot or zero, registered
//   rq_sck      in   [1:0] per-requester SPI clock
//   rq_mosi     in   [1:0] per-requester SPI MOSI
//   rq_csn      in   [1:0] per-requester chip select, active low
//   rq_miso     out  [1:0] flash MISO routed to the owner, 0 elsewhere
//   flash_clk   out  flash clock / USRMCLKI, registered
//   flash_mosi  out  flash MOSI, registered
//   flash_csn   out  flash chip select / USRMCLKTS, registered, active low
//   flash_miso  in   flash MISO
//   busy        out  high in every state except IDLE
//   dbg_state   out  [1:0] FSM state (0 IDLE, 1 GRANT, 2 GUARD)
//
// Handshake: a requester raises rq_req and waits for its rq_gnt bit; while
// granted its rq_sck/rq_mosi/rq_csn reach the flash one cycle later. The
// grant is only withdrawn on a cycle where that requester's rq_csn is high,
// either because rq_req dropped or because the hold limit expired while the
// other requester is waiting.

module spi_flash_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int HOLD_LIMIT   = 4096
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [1:0] rq_req,
  output logic [1:0] rq_gnt,
  input  logic [1:0] rq_sck,
  input  logic [1:0] rq_mosi,
  input  logic [1:0] rq_csn,
  output logic [1:0] rq_miso,
  output logic       flash_clk,
  output logic       flash_mosi,
  output logic       flash_csn,
  input  logic       flash_miso,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int HW = (HOLD_LIMIT < 2) ? 1 : $clog2(HOLD_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_owner, w_owner_nxt;
  logic            r_last,  w_last_nxt;
  logic [1:0]      r_gnt,   w_gnt_nxt;
  logic [HW-1:0]   r_hold,  w_hold_nxt;
  logic [7:0]      r_guard, w_guard_nxt;
  logic            r_fclk,  w_fclk_nxt;
  logic            r_fmosi, w_fmosi_nxt;
  logic            r_fcsn,  w_fcsn_nxt;

  logic            w_other;
  logic            w_pick;
  logic            w_hold_hit;
  logic            w_release;

  assign w_other = ~r_owner;

  // On a tie the requester that did not own the bus last wins.
  assign w_pick = (rq_req == 2'b11) ? ~r_last : rq_req[1];

  assign w_hold_hit = (HOLD_LIMIT != 0) && (r_hold >= HW'(HOLD_LIMIT));

  assign w_release = rq_csn[r_owner] &&
                     (!rq_req[r_owner] || (w_hold_hit && rq_req[w_other]));

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    w_hold_nxt  = r_hold;
    w_guard_nxt = r_guard;
    // Bus parked unless the owner is actively driving it.
    w_fclk_nxt  = 1'b0;
    w_fmosi_nxt = 1'b0;
    w_fcsn_nxt  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = 2'b00;
        if (rq_req != 2'b00) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_pick;
          w_last_nxt  = w_pick;
          w_gnt_nxt   = w_pick ? 2'b10 : 2'b01;
          w_hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_GUARD;
          w_gnt_nxt   = 2'b00;
          w_guard_nxt = 8'd0;
        end else begin
          w_fclk_nxt  = rq_sck[r_owner];
          w_fmosi_nxt = rq_mosi[r_owner];
          w_fcsn_nxt  = rq_csn[r_owner];
          if (r_hold < HW'(HOLD_LIMIT)) w_hold_nxt = r_hold + 1'b1;
        end
      end
      ST_GUARD: begin
        w_gnt_nxt = 2'b00;
        if (r_guard == 8'(GUARD_CYCLES - 1)) w_state_nxt = ST_IDLE;
        else                                 w_guard_nxt = r_guard + 8'd1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
      r_hold  <= '0;
      r_guard <= 8'd0;
      r_fclk  <= 1'b0;
      r_fmosi <= 1'b0;
      r_fcsn  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_hold  <= w_hold_nxt;
      r_guard <= w_guard_nxt;
      r_fclk  <= w_fclk_nxt;
      r_fmosi <= w_fmosi_nxt;
      r_fcsn  <= w_fcsn_nxt;
    end
  end

  // The grant is nonzero only in GRANT and marks the owner, so it gates MISO.
  assign rq_miso    = r_gnt & {2{flash_miso}};
  assign rq_gnt     = r_gnt;
  assign flash_clk  = r_fclk;
  assign flash_mosi = r_fmosi;
  assign flash_csn  = r_fcsn;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b1;
  logic [1:0] rq_req    = 2'b00;
  logic [1:0] rq_gnt;
  logic [1:0] rq_sck    = 2'b00;
  logic [1:0] rq_mosi   = 2'b00;
  logic [1:0] rq_csn    = 2'b11;
  logic [1:0] rq_miso;
  logic       flash_clk;
  logic       flash_mosi;
  logic       flash_csn;
  logic       flash_miso = 1'b0;
  logic       busy;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];

  spi_flash_arbiter #(.GUARD_CYCLES(4), .HOLD_LIMIT(16)) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .rq_req    (rq_req),
    .rq_gnt    (rq_gnt),
    .rq_sck    (rq_sck),
    .rq_mosi   (rq_mosi),
    .rq_csn    (rq_csn),
    .rq_miso   (rq_miso),
    .flash_clk (flash_clk),
    .flash_mosi(flash_mosi),
    .flash_csn (flash_csn),
    .flash_miso(flash_miso),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #10 clk_48mhz = ~clk_48mhz;

  task automatic step;
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    rq_req  = 2'b00;
    rq_sck  = 2'b00;
    rq_mosi = 2'b00;
    rq_csn  = 2'b11;
    step();
    step();
    reset = 1'b0;
  endtask

  // grant must never be 11 nor present outside GRANT
  always @(negedge clk_48mhz) begin
    if (!reset) begin
      total++;
      if (rq_gnt == 2'b11 || (rq_gnt != 2'b00 && dbg_state != 2'd1)) begin
        bad++;
        $display("FAIL gnt_legal: gnt=%b state=%0d", rq_gnt, dbg_state);
      end
    end
  end

  // Owner o drives n random SPI bit cycles with csn low; expected pin values
  // are queued on drive and compared one edge later.
  task automatic run_bytes(input int o, input int n, input bit tog, input bit req_val);
    logic [1:0] exp_miso;
    logic [2:0] exp_pins;
    for (int i = 0; i < n; i++) begin
      rq_req[o]  = req_val;
      rq_sck[o]  = 1'($urandom_range(0, 1));
      rq_mosi[o] = 1'($urandom_range(0, 1));
      rq_csn[o]  = 1'b0;
      if (tog) begin
        rq_sck[1-o]  = 1'($urandom_range(0, 1));
        rq_mosi[1-o] = 1'($urandom_range(0, 1));
        rq_csn[1-o]  = 1'($urandom_range(0, 1));
      end
      flash_miso = 1'($urandom_range(0, 1));
      #1;
      exp_miso = (o == 1) ? {flash_miso, 1'b0} : {1'b0, flash_miso};
      total++;
      if (rq_miso !== exp_miso) begin
        bad++;
        $display("FAIL miso_route: got=%b exp=%b", rq_miso, exp_miso);
      end
      exp_q.push_back({rq_sck[o], rq_mosi[o], 1'b0});
      step();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pins_queue: got=empty exp=entry");
      end else begin
        exp_pins = exp_q.pop_front();
        if ({flash_clk, flash_mosi, flash_csn} !== exp_pins) begin
          bad++;
          $display("FAIL pins_follow: got=%b exp=%b", {flash_clk, flash_mosi, flash_csn}, exp_pins);
        end
      end
    end
  endtask

  // After a release edge: 4 GUARD cycles, 1 IDLE cycle, then exp_gnt (or 00).
  task automatic check_guard(input logic [1:0] exp_gnt);
    for (int i = 1; i <= 5; i++) begin
      step();
      total++;
      if (flash_csn !== 1'b1 || (i < 5 && rq_gnt !== 2'b00)) begin
        bad++;
        $display("FAIL guard_gap: cyc=%0d csn=%b gnt=%b", i, flash_csn, rq_gnt);
      end
    end
    total++;
    if (rq_gnt !== exp_gnt) begin
      bad++;
      $display("FAIL after_guard: got=%b exp=%b", rq_gnt, exp_gnt);
    end
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({rq_gnt, flash_csn, flash_clk, flash_mosi, busy, dbg_state, rq_miso} !== {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00}) begin
      bad++;
      $display("FAIL reset_vals: gnt=%b csn=%b clk=%b mosi=%b busy=%b st=%0d",
               rq_gnt, flash_csn, flash_clk, flash_mosi, busy, dbg_state);
    end
  endtask

  task automatic test_single;
    do_reset();
    rq_req = 2'b01;
    step();
    total++;
    if (rq_gnt !== 2'b01 || busy !== 1'b1 || flash_csn !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt=%b busy=%b csn=%b exp 01 1 1", rq_gnt, busy, flash_csn);
    end
    run_bytes(0, 16, 1'b0, 1'b1);
    rq_csn[0] = 1'b1;
    rq_req[0] = 1'b0;
    step();
    total++;
    if (rq_gnt !== 2'b00 || flash_csn !== 1'b1 || flash_clk !== 1'b0 || dbg_state !== 2'd2) begin
      bad++;
      $display("FAIL single_release: gnt=%b csn=%b clk=%b st=%0d", rq_gnt, flash_csn, flash_clk, dbg_state);
    end
    check_guard(2'b00);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: busy=%b exp=0", busy);
    end
  endtask

  task automatic test_tie;
    do_reset();
    rq_req = 2'b11;
    step();
    total++;
    if (rq_gnt !== 2'b01) begin
      bad++;
      $display("FAIL tie_first: got=%b exp=01", rq_gnt);
    end
    run_bytes(0, 8, 1'b0, 1'b1);
    rq_csn[0] = 1'b1;
    rq_req[0] = 1'b0;
    step();
    check_guard(2'b10);
    run_bytes(1, 6, 1'b0, 1'b1);
    rq_csn[1] = 1'b1;
    rq_req    = 2'b11;
    step();
    // req1 still requested, so no release yet; drop it next
    rq_req[1] = 1'b0;
    step();
    check_guard(2'b01);
  endtask

  task automatic test_drop_mid_byte;
    do_reset();
    rq_req = 2'b01;
    step();
    run_bytes(0, 4, 1'b0, 1'b1);
    run_bytes(0, 6, 1'b0, 1'b0);
    total++;
    if (rq_gnt !== 2'b01 || flash_csn !== 1'b0) begin
      bad++;
      $display("FAIL drop_hold: gnt=%b csn=%b exp 01 0", rq_gnt, flash_csn);
    end
    rq_csn[0] = 1'b1;
    step();
    total++;
    if (rq_gnt !== 2'b00 || flash_csn !== 1'b1) begin
      bad++;
      $display("FAIL drop_release: gnt=%b csn=%b exp 00 1", rq_gnt, flash_csn);
    end
  endtask

  task automatic test_preempt;
    do_reset();
    rq_req = 2'b11;
    step();
    for (int c = 0; c < 24; c++) begin
      rq_csn[0] = (c % 8 == 7);
      rq_sck[0] = 1'($urandom_range(0, 1));
      step();
      total++;
      if (rq_gnt !== ((c < 23) ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL preempt_c%0d: got=%b exp=%b", c, rq_gnt, (c < 23) ? 2'b01 : 2'b00);
      end
    end
    check_guard(2'b10);
  endtask

  task automatic test_nonowner_toggle;
    do_reset();
    rq_req = 2'b01;
    step();
    run_bytes(0, 20, 1'b1, 1'b1);
    rq_csn = 2'b11;
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    rq_req = 2'b01;
    step();
    run_bytes(0, 5, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    total++;
    if (flash_csn !== 1'b1 || rq_gnt !== 2'b00 || busy !== 1'b0 || flash_clk !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: csn=%b gnt=%b busy=%b clk=%b", flash_csn, rq_gnt, busy, flash_clk);
    end
    reset  = 1'b0;
    rq_req = 2'b10;
    rq_csn = 2'b11;
    step();
    total++;
    if (rq_gnt !== 2'b10) begin
      bad++;
      $display("FAIL reset_regrant: got=%b exp=10", rq_gnt);
    end
    run_bytes(1, 6, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_drop_mid_byte();
    test_preempt();
    test_nonowner_toggle();
    test_reset_mid_grant();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
